// File: rtl/alu_pkg.sv
// Shared widths and operation encodings for the alu_modport execute block.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 7;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned SHIFT_W = $clog2(DATA_W);

  typedef enum logic [OP_W-1:0] {
    OPSEL_SHIFT     = 3'b000,
    OPSEL_ARITH     = 3'b001,
    OPSEL_MEM_WRITE = 3'b100,
    OPSEL_MEM_READ  = 3'b101
  } opsel_e;

  typedef enum logic [OP_W-1:0] {
    ARITH_ADD  = 3'b000,
    ARITH_HADD = 3'b001,
    ARITH_SUB  = 3'b010,
    ARITH_NOT  = 3'b011,
    ARITH_AND  = 3'b100,
    ARITH_OR   = 3'b101,
    ARITH_XOR  = 3'b110,
    ARITH_PASS = 3'b111
  } arith_op_e;

  typedef enum logic [OP_W-1:0] {
    SHIFT_SLL = 3'b000,
    SHIFT_SLA = 3'b001,
    SHIFT_SRL = 3'b010,
    SHIFT_SRA = 3'b011
  } shift_op_e;

endpackage

// File: rtl/alu_modport_exec.sv
// Combinational result/carry function of the stage-1 registers.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned N = DATA_W,
  parameter int unsigned S = SHIFT_W
) (
  input  logic [N-1:0] aluin1,
  input  logic [N-1:0] aluin2,
  input  logic [2:0]   operation,
  input  logic [S-1:0] shift_number,
  input  logic         enable_arith,
  input  logic         enable_shift,
  output logic [N-1:0] result,
  output logic         carry_out,
  output logic         result_valid
);

  logic [N:0]  sum;
  logic [16:0] hsum;

  always_comb begin
    result       = '0;
    carry_out    = 1'b0;
    sum          = '0;
    hsum         = '0;
    result_valid = enable_arith | enable_shift;
    if (enable_arith) begin
      case (operation)
        ARITH_ADD: begin
          sum                 = {1'b0, aluin1} + {1'b0, aluin2};
          {carry_out, result} = sum;
        end
        ARITH_HADD: begin
          hsum      = {1'b0, aluin1[15:0]} + {1'b0, aluin2[15:0]};
          result    = {{(N-16){1'b0}}, hsum[15:0]};
          carry_out = hsum[16];
        end
        ARITH_SUB: begin
          // Carry out of a+~b+1 is the inverted borrow.
          sum                 = {1'b0, aluin1} + {1'b0, ~aluin2} + {{N{1'b0}}, 1'b1};
          {carry_out, result} = sum;
        end
        ARITH_NOT: result = ~aluin2;
        ARITH_AND: result = aluin1 & aluin2;
        ARITH_OR:  result = aluin1 | aluin2;
        ARITH_XOR: result = aluin1 ^ aluin2;
        default:   result = aluin2;
      endcase
    end else if (enable_shift) begin
      case (operation)
        SHIFT_SLL, SHIFT_SLA: result = aluin1 << shift_number;
        SHIFT_SRL:            result = aluin1 >> shift_number;
        SHIFT_SRA:            result = $unsigned($signed(aluin1) >>> shift_number);
        default:              result = aluin1;
      endcase
    end
  end

endmodule

// File: rtl/alu_modport.sv
// Two-stage ALU execute block: stage-1 decode/operand registers, stage-2 result.
// Memory read/write opselects are enabled by defining ALU_MEMOP_EN.
module alu_modport
  import alu_pkg::*;
#(
  parameter int unsigned N = DATA_W,
  parameter int unsigned S = SHIFT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_ex,
  input  logic [N-1:0]      src1,
  input  logic [N-1:0]      src2,
  input  logic [N-1:0]      imm,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [N-1:0]      memory_data_read_in,
  output logic [N-1:0]      aluin1,
  output logic [N-1:0]      aluin2,
  output logic [OP_W-1:0]   operation_out,
  output logic [OP_W-1:0]   opselect_out,
  output logic [S-1:0]      shift_number,
  output logic              enable_arith,
  output logic              enable_shift,
  output logic [N-1:0]      mem_data_write_out,
  output logic              mem_write_en,
  output logic [N-1:0]      aluout,
  output logic              carry
);

  logic [OP_W-1:0] op_in;
  logic [OP_W-1:0] opsel_in;
  logic            imm_sel;

  assign op_in    = control_in[2:0];
  assign imm_sel  = control_in[3];
  assign opsel_in = control_in[6:4];

  logic [N-1:0]    aluin1_q, aluin1_d;
  logic [N-1:0]    aluin2_q, aluin2_d;
  logic [OP_W-1:0] operation_q, operation_d;
  logic [OP_W-1:0] opselect_q, opselect_d;
  logic [S-1:0]    shift_number_q, shift_number_d;
  logic            enable_arith_q, enable_arith_d;
  logic            enable_shift_q, enable_shift_d;
  logic [N-1:0]    mem_data_write_q, mem_data_write_d;
  logic            mem_write_en_q, mem_write_en_d;
  logic [N-1:0]    aluout_q, aluout_d;
  logic            carry_q, carry_d;

  logic [N-1:0]    exec_result;
  logic            exec_carry;
  logic            exec_valid;

  always_comb begin
    aluin1_d         = aluin1_q;
    aluin2_d         = aluin2_q;
    operation_d      = operation_q;
    opselect_d       = opselect_q;
    shift_number_d   = shift_number_q;
    mem_data_write_d = mem_data_write_q;
    enable_arith_d   = 1'b0;
    enable_shift_d   = 1'b0;
    mem_write_en_d   = 1'b0;
    if (enable_ex) begin
      case (opsel_in)
        OPSEL_ARITH: begin
          aluin1_d       = src1;
          aluin2_d       = imm_sel ? imm : src2;
          operation_d    = op_in;
          opselect_d     = opsel_in;
          enable_arith_d = 1'b1;
        end
        OPSEL_SHIFT: begin
          aluin1_d       = src1;
          shift_number_d = imm_sel ? imm[S-1:0] : src2[S-1:0];
          operation_d    = op_in;
          opselect_d     = opsel_in;
          enable_shift_d = 1'b1;
        end
`ifdef ALU_MEMOP_EN
        OPSEL_MEM_READ: begin
          aluin1_d       = src1;
          aluin2_d       = memory_data_read_in;
          operation_d    = ARITH_PASS;
          opselect_d     = opsel_in;
          enable_arith_d = 1'b1;
        end
        OPSEL_MEM_WRITE: begin
          aluin1_d         = src1;
          mem_data_write_d = src2;
          operation_d      = op_in;
          opselect_d       = opsel_in;
          mem_write_en_d   = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  alu_exec #(
    .N (N),
    .S (S)
  ) u_exec (
    .aluin1       (aluin1_q),
    .aluin2       (aluin2_q),
    .operation    (operation_q),
    .shift_number (shift_number_q),
    .enable_arith (enable_arith_q),
    .enable_shift (enable_shift_q),
    .result       (exec_result),
    .carry_out    (exec_carry),
    .result_valid (exec_valid)
  );

  always_comb begin
    aluout_d = exec_valid ? exec_result : aluout_q;
    carry_d  = exec_valid ? exec_carry  : carry_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      aluin1_q         <= '0;
      aluin2_q         <= '0;
      operation_q      <= '0;
      opselect_q       <= '0;
      shift_number_q   <= '0;
      enable_arith_q   <= 1'b0;
      enable_shift_q   <= 1'b0;
      mem_data_write_q <= '0;
      mem_write_en_q   <= 1'b0;
      aluout_q         <= '0;
      carry_q          <= 1'b0;
    end else begin
      aluin1_q         <= aluin1_d;
      aluin2_q         <= aluin2_d;
      operation_q      <= operation_d;
      opselect_q       <= opselect_d;
      shift_number_q   <= shift_number_d;
      enable_arith_q   <= enable_arith_d;
      enable_shift_q   <= enable_shift_d;
      mem_data_write_q <= mem_data_write_d;
      mem_write_en_q   <= mem_write_en_d;
      aluout_q         <= aluout_d;
      carry_q          <= carry_d;
    end
  end

  assign aluin1        = aluin1_q;
  assign aluin2        = aluin2_q;
  assign operation_out = operation_q;
  assign opselect_out  = opselect_q;
  assign shift_number  = shift_number_q;
  assign enable_arith  = enable_arith_q;
  assign enable_shift  = enable_shift_q;
  assign aluout        = aluout_q;
  assign carry         = carry_q;

`ifdef ALU_MEMOP_EN
  assign mem_data_write_out = mem_data_write_q;
  assign mem_write_en       = mem_write_en_q;
`else
  // Store path is compiled out; its flops never load and are left unread.
  logic unused_store;
  assign unused_store       = ^{memory_data_read_in, mem_data_write_q, mem_write_en_q};
  assign mem_data_write_out = '0;
  assign mem_write_en       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_modport.sv
// Self-checking bench for alu_modport: directed scenarios plus a randomized run
// against a behavioural model of the two-stage pipeline.
module tb_alu_modport;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_ex = 1'b0;
  logic [31:0] src1 = '0, src2 = '0, imm = '0, memory_data_read_in = '0;
  logic [6:0]  control_in = '0;
  logic [31:0] aluin1, aluin2, mem_data_write_out, aluout;
  logic [2:0]  operation_out, opselect_out;
  logic [4:0]  shift_number;
  logic        enable_arith, enable_shift, mem_write_en, carry;

  int checks = 0;
  int errors = 0;

  alu_modport #(.N(32), .S(5)) dut (
    .clock(clock), .reset(reset), .enable_ex(enable_ex),
    .src1(src1), .src2(src2), .imm(imm), .control_in(control_in),
    .memory_data_read_in(memory_data_read_in),
    .aluin1(aluin1), .aluin2(aluin2), .operation_out(operation_out),
    .opselect_out(opselect_out), .shift_number(shift_number),
    .enable_arith(enable_arith), .enable_shift(enable_shift),
    .mem_data_write_out(mem_data_write_out), .mem_write_en(mem_write_en),
    .aluout(aluout), .carry(carry)
  );

  always #5 clock = ~clock;

`ifdef ALU_MEMOP_EN
  localparam bit MEMOP = 1'b1;
`else
  localparam bit MEMOP = 1'b0;
`endif

  // Model state: what each output should hold after the next edge.
  logic [31:0] m_a1 = '0, m_a2 = '0, m_wd = '0, m_out = '0;
  logic [2:0]  m_op = '0, m_sel = '0;
  logic [4:0]  m_sh = '0;
  logic        m_ea = 1'b0, m_es = 1'b0, m_we = 1'b0, m_c = 1'b0;

  task automatic model_clock();
    logic [63:0] wide;
    logic [2:0]  sel;
    if (!reset) begin
      m_a1 = '0; m_a2 = '0; m_wd = '0; m_out = '0; m_op = '0; m_sel = '0;
      m_sh = '0; m_ea = 0; m_es = 0; m_we = 0; m_c = 0;
      return;
    end
    if (m_ea) begin
      m_c = 1'b0;
      case (m_op)
        3'd0: begin wide = 64'(m_a1) + 64'(m_a2); m_out = wide[31:0]; m_c = wide[32]; end
        3'd1: begin wide = 64'(m_a1 & 32'hFFFF) + 64'(m_a2 & 32'hFFFF);
                    m_out = wide[31:0] & 32'hFFFF; m_c = wide[16]; end
        3'd2: begin m_out = m_a1 - m_a2; m_c = (m_a1 >= m_a2); end
        3'd3: m_out = ~m_a2;
        3'd4: m_out = m_a1 & m_a2;
        3'd5: m_out = m_a1 | m_a2;
        3'd6: m_out = m_a1 ^ m_a2;
        default: m_out = m_a2;
      endcase
    end else if (m_es) begin
      m_c = 1'b0;
      case (m_op)
        3'd0, 3'd1: m_out = m_a1 << m_sh;
        3'd2: m_out = m_a1 >> m_sh;
        3'd3: m_out = (m_a1 >> m_sh) | (m_a1[31] ? ~(32'hFFFF_FFFF >> m_sh) : 32'h0);
        default: m_out = m_a1;
      endcase
    end
    m_ea = 0; m_es = 0; m_we = 0;
    sel = control_in[6:4];
    if (enable_ex) begin
      if (sel == 3'b001) begin
        m_a1 = src1; m_a2 = control_in[3] ? imm : src2;
        m_op = control_in[2:0]; m_sel = sel; m_ea = 1;
      end else if (sel == 3'b000) begin
        m_a1 = src1; m_sh = control_in[3] ? imm[4:0] : src2[4:0];
        m_op = control_in[2:0]; m_sel = sel; m_es = 1;
      end else if (MEMOP && sel == 3'b101) begin
        m_a1 = src1; m_a2 = memory_data_read_in; m_op = 3'b111; m_sel = sel; m_ea = 1;
      end else if (MEMOP && sel == 3'b100) begin
        m_a1 = src1; m_wd = src2; m_op = control_in[2:0]; m_sel = sel; m_we = 1;
      end
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; enable_ex = 1;
    src1 = $urandom; src2 = $urandom; imm = $urandom; control_in = 7'b001_0_000;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({aluin1, aluin2, operation_out, opselect_out, shift_number, enable_arith,
           enable_shift, mem_data_write_out, mem_write_en, aluout, carry} !== '0) begin
        errors++;
        $display("FAIL reset cycle %0d: aluout=%h aluin1=%h en_a=%b en_s=%b we=%b required all zero",
                 i, aluout, aluin1, enable_arith, enable_shift, mem_write_en);
      end
    end
    reset = 1; enable_ex = 0;
  endtask

  task automatic test_add_carry();
    enable_ex = 1; src1 = 32'hFFFF_FFFF; src2 = 32'h1; control_in = 7'b001_0_000;
    step();
    enable_ex = 0;
    checks++;
    if (enable_arith !== 1'b1 || aluin2 !== 32'h1) begin
      errors++; $display("FAIL add_stage1: en_a=%b aluin2=%h required 1/00000001", enable_arith, aluin2);
    end
    step();
    checks++;
    if (aluout !== 32'h0 || carry !== 1'b1) begin
      errors++; $display("FAIL add_carry: aluout=%h carry=%b required 00000000/1", aluout, carry);
    end
  endtask

  task automatic test_sub_imm();
    enable_ex = 1; src1 = 32'd5; imm = 32'd7; src2 = 32'h1234; control_in = 7'b001_1_010;
    step();
    enable_ex = 0;
    step();
    checks++;
    if (aluout !== 32'hFFFF_FFFE || carry !== 1'b0) begin
      errors++; $display("FAIL sub_imm: aluout=%h carry=%b required fffffffe/0", aluout, carry);
    end
  endtask

  task automatic test_sra();
    enable_ex = 1; src1 = 32'h8000_0000; src2 = 32'd4; control_in = 7'b000_0_011;
    step();
    enable_ex = 0;
    checks++;
    if (shift_number !== 5'd4 || enable_shift !== 1'b1) begin
      errors++; $display("FAIL sra_stage1: shift_number=%0d en_s=%b required 4/1", shift_number, enable_shift);
    end
    step();
    checks++;
    if (aluout !== 32'hF800_0000 || carry !== 1'b0) begin
      errors++; $display("FAIL sra: aluout=%h carry=%b required f8000000/0", aluout, carry);
    end
  endtask

  task automatic test_store();
    enable_ex = 1; src2 = 32'hDEAD_BEEF; control_in = 7'b100_0_000;
    step();
    enable_ex = 0;
    checks++;
    if (mem_write_en !== MEMOP || mem_data_write_out !== (MEMOP ? 32'hDEAD_BEEF : 32'h0)) begin
      errors++; $display("FAIL store_pulse: we=%b data=%h required %b/%h", mem_write_en,
                         mem_data_write_out, MEMOP, MEMOP ? 32'hDEAD_BEEF : 32'h0);
    end
    step();
    checks++;
    if (mem_write_en !== 1'b0) begin
      errors++; $display("FAIL store_one_cycle: we=%b required 0", mem_write_en);
    end
    checks++;
    if (aluout !== 32'hF800_0000 || enable_arith !== 1'b0) begin
      errors++; $display("FAIL store_aluout_hold: aluout=%h en_a=%b required f8000000/0", aluout, enable_arith);
    end
  endtask

  task automatic test_bubble_hold();
    enable_ex = 1; src1 = 32'd10; src2 = 32'd20; control_in = 7'b001_0_000;
    step();
    enable_ex = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (enable_arith !== 1'b0 || aluout !== 32'd30) begin
        errors++; $display("FAIL bubble_hold cycle %0d: en_a=%b aluout=%h required 0/0000001e",
                           i, enable_arith, aluout);
      end
    end
  endtask

  task automatic test_reset_midflight();
    enable_ex = 1; src1 = 32'd1; src2 = 32'd2; control_in = 7'b001_0_000;
    step();
    enable_ex = 0; reset = 0;
    step();
    reset = 1;
    checks++;
    if (aluout !== 32'h0 || enable_arith !== 1'b0 || aluin1 !== 32'h0) begin
      errors++; $display("FAIL reset_midflight: aluout=%h en_a=%b aluin1=%h required 0/0/0",
                         aluout, enable_arith, aluin1);
    end
    step();
    checks++;
    if (aluout !== 32'h0 || carry !== 1'b0) begin
      errors++; $display("FAIL reset_discard: aluout=%h carry=%b required 0/0", aluout, carry);
    end
  endtask

  task automatic test_random();
    logic [2:0] sel;
    int unsigned r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    sel = 3'b000;
        2, 3, 4: sel = 3'b001;
        5, 6:    sel = 3'b101;
        7, 8:    sel = 3'b100;
        default: sel = 3'($urandom_range(2, 3) | ($urandom_range(0, 1) << 2));
      endcase
      enable_ex = ($urandom_range(0, 7) != 0);
      src1 = $urandom; src2 = $urandom; imm = $urandom; memory_data_read_in = $urandom;
      if ($urandom_range(0, 3) == 0) src1 = src1 | 32'h8000_0000;
      control_in = {sel, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
      step();
      checks++;
      if (aluout !== m_out || carry !== m_c) begin
        errors++; $display("FAIL rand_result %0d: aluout=%h carry=%b required %h/%b", i, aluout, carry, m_out, m_c);
      end
      checks++;
      if (aluin1 !== m_a1 || aluin2 !== m_a2 || shift_number !== m_sh) begin
        errors++; $display("FAIL rand_operands %0d: a1=%h a2=%h sh=%0d required %h/%h/%0d",
                           i, aluin1, aluin2, shift_number, m_a1, m_a2, m_sh);
      end
      checks++;
      if (operation_out !== m_op || opselect_out !== m_sel) begin
        errors++; $display("FAIL rand_codes %0d: op=%b sel=%b required %b/%b", i, operation_out, opselect_out, m_op, m_sel);
      end
      checks++;
      if (enable_arith !== m_ea || enable_shift !== m_es || mem_write_en !== m_we) begin
        errors++; $display("FAIL rand_enables %0d: en_a=%b en_s=%b we=%b required %b/%b/%b",
                           i, enable_arith, enable_shift, mem_write_en, m_ea, m_es, m_we);
      end
      checks++;
      if (mem_data_write_out !== m_wd) begin
        errors++; $display("FAIL rand_store_data %0d: data=%h required %h", i, mem_data_write_out, m_wd);
      end
    end
    enable_ex = 0;
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_imm();
    test_sra();
    test_store();
    test_bubble_hold();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
